// File: rtl/fir_out_requant.sv
// Requantizer behind the 63-tap FIR: round-half-up shift, 16-bit saturation, decimation, small output FIFO.
// Optional saturation event counter enabled by defining FIR_REQUANT_SAT_COUNT_EN.
module fir_out_requant #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 8,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    sat_pulse,
    output logic                    ovf_flag,
    input  logic                    clr_ovf
`ifdef FIR_REQUANT_SAT_COUNT_EN
    ,
    output logic [15:0]             sat_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [IN_W:0]        RND  = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W:0] MINV = -MAXV - 1;

    logic signed [IN_W:0]    w_sum;
    logic signed [IN_W:0]    w_q;
    logic                    w_satHi;
    logic                    w_satLo;
    logic signed [OUT_W-1:0] w_qSat;

    logic                    r_s1Valid;
    logic signed [OUT_W-1:0] r_s1Data;
    logic                    r_satPulse;
    logic [CW-1:0]           r_decCnt;

    logic signed [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]             r_wrPtr;
    logic [AW:0]             r_rdPtr;
    logic                    r_ovf;

    logic w_cand;
    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;
    logic w_drop;

    // One extra sign bit on the sum means adding the rounding constant can never wrap.
    always_comb begin
        w_sum   = $signed({in_data[IN_W-1], in_data}) + $signed(RND);
        w_q     = w_sum >>> SHIFT;
        w_satHi = (w_q > MAXV);
        w_satLo = (w_q < MINV);
        if (w_satHi)
            w_qSat = {1'b0, {(OUT_W-1){1'b1}}};
        else if (w_satLo)
            w_qSat = {1'b1, {(OUT_W-1){1'b0}}};
        else
            w_qSat = w_q[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Data   <= '0;
            r_satPulse <= 1'b0;
        end else begin
            r_s1Valid  <= in_valid;
            r_satPulse <= in_valid && (w_satHi || w_satLo);
            if (in_valid)
                r_s1Data <= w_qSat;
        end
    end

    assign w_cand  = r_s1Valid && (r_decCnt == '0);
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_rd    = !w_empty && out_ready;
    assign w_wr    = w_cand && (!w_full || w_rd);
    assign w_drop  = w_cand && !w_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_decCnt <= '0;
        end else if (r_s1Valid) begin
            if (r_decCnt == CW'(DECIM - 1))
                r_decCnt <= '0;
            else
                r_decCnt <= r_decCnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wr)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_rd)
                r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wrPtr[AW-1:0]] <= r_s1Data;
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (clr_ovf)
            r_ovf <= 1'b0;
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
    assign sat_pulse = r_satPulse;
    assign ovf_flag  = r_ovf;

`ifdef FIR_REQUANT_SAT_COUNT_EN
    logic [15:0] r_satCount;

    always_ff @(posedge clk) begin
        if (rst || clr_ovf)
            r_satCount <= '0;
        else if (r_satPulse && (r_satCount != 16'hFFFF))
            r_satCount <= r_satCount + 16'd1;
    end

    assign sat_count = r_satCount;
`endif

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Downstream stage of the 63-tap FIR filter block.
- Takes the filter's 32-bit signed output, rounds and shifts it, saturates it to 16 bits, and decimates by a fixed ratio.
- Buffers the results in a small FIFO with a valid/ready output, so a stalling consumer (DAC interface, capture logic) never stalls the filter.
- The filter cannot be back-pressured. When the FIFO is full, new samples are dropped and the drop is flagged.

Parameters:
- IN_W, 32, input sample width (matches filter y_out).
- OUT_W, 16, output sample width, must be < IN_W.
- SHIFT, 8, right-shift applied after rounding, range 1..IN_W-OUT_W.
- DECIM, 2, decimation ratio, range 1..256; 1 means no decimation.
- FIFO_DEPTH, 4, entries, power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  qualifies in_data; driven by the filter's ena delayed one cycle
- in_data  in  IN_W  signed filter output sample
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid and out_ready are both high
- out_data  out  OUT_W  signed requantized sample at FIFO head
- sat_pulse  out  1  one-cycle pulse: the sample in stage 1 was saturated
- ovf_flag  out  1  sticky: a decimated sample was dropped because the FIFO was full
- clr_ovf  in  1  clears ovf_flag

Behaviour:
- Reset is synchronous, sampled on the clk rising edge while rst=1. On reset:
  - FIFO empty and out_valid=0; out_data=0.
  - sat_pulse=0, ovf_flag=0.
  - Decimation counter=0; stage-1 valid=0.
  - Reset mid-operation discards all FIFO contents and any in-flight stage-1 sample.
- Stage 1 (registered, latency 1):
  - sum = sign-extended in_data (IN_W+1 bits) + 2^(SHIFT-1); q = sum >>> SHIFT (arithmetic shift). This is round-half-up and cannot overflow internally.
  - If q > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1. If q < -2^(OUT_W-1), output -2^(OUT_W-1). In either case sat_pulse=1 on the cycle the stage-1 result is valid.
  - sat_pulse is 0 on every other cycle.
- Stage 2 (decimation and FIFO write):
  - Each valid stage-1 sample advances the counter 0 → DECIM-1, then wraps to 0.
  - Only the sample seen while counter=0 is a write candidate, so the first sample after reset is always kept.
  - Invalid cycles do not advance the counter.
- FIFO behaviour:
  - Write succeeds if the FIFO is not full, or if it is full and a read occurs in the same cycle.
  - A candidate that cannot be written is dropped and sets ovf_flag on the next edge.
  - Simultaneous read and write when empty is impossible: out_valid is low when empty.
  - Simultaneous read and write at other fill levels keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
- Output:
  - out_valid = not empty; out_data = head entry.
  - Head is stable while out_valid=1 and out_ready=0.
  - Latency with the FIFO empty: in_data on edge N gives out_valid=1 after edge N+2.
  - out_ready while empty is ignored.
- ovf_flag:
  - clr_ovf=1 clears it on the next edge.
  - If clr_ovf and a drop occur in the same cycle, set wins: flag = 1.
- Throughput: one input per cycle sustained; with DECIM=1 and out_ready held high, no drops.

Optional Feature:
- Macro: FIR_REQUANT_SAT_COUNT_EN.
- Defined:
  - Adds output port sat_count, 16 bits, unsigned: the number of sat_pulse events.
  - Saturates at 0xFFFF; does not wrap.
  - Reset to 0 by rst; cleared by clr_ovf.
- Undefined: port and counter logic absent; all other behaviour identical.

Test Plan:
All scenarios use the defaults (SHIFT=8, DECIM=2, OUT_W=16, FIFO_DEPTH=4) unless stated; out_ready=1 unless stated.
- Rounding: single in_data=0x00000180 (384) → out_data=0x0002 with out_valid two cycles later. Single in_data=0xFFFFFE80 (-384) → 0xFFFF (-1). sat_pulse stays 0 throughout.
- Saturation: in_data=0x7FFFFFFF → 0x7FFF; in_data=0x80000000 → 0x8000. sat_pulse=1 for exactly one cycle each; with FIR_REQUANT_SAT_COUNT_EN, sat_count=2.
- Decimation: six consecutive valid samples 256,512,...,1536 → outputs 1,3,5 in order. With gaps in in_valid between samples → same outputs.
- Overflow: out_ready=0, ten consecutive samples 256*k for k=1..10 → five candidates (1,3,5,7,9).
  - FIFO holds 1,3,5,7; 9 is dropped; ovf_flag=1.
  - Then out_ready=1 → drains 1,3,5,7 and out_valid falls.
  - A clr_ovf pulse then clears ovf_flag.
- Full plus simultaneous read: FIFO full with out_ready=1 on the same cycle a candidate arrives → candidate written, no drop, count stays 4.
- Reset mid-operation: three entries stored, rst high for one cycle → next cycle out_valid=0, ovf_flag=0. Next sample 0x00000300 is kept (counter=0) and appears as 0x0003.
